// File: rtl/video_timing_pkg.sv
// Geometry constant sets (NTSC 525i, PAL 625i) and shared types for the composite timing path.
package video_timing_pkg;

    localparam int DEFAULT_CNT_W = 11;

    localparam int NTSC_H_TOTAL          = 1588;
    localparam int NTSC_H_SYNC           = 118;
    localparam int NTSC_H_BACK_PORCH     = 152;
    localparam int NTSC_H_ACTIVE         = 1280;
    localparam int NTSC_H_VSYNC_PULSE_LEN = 678;
    localparam int NTSC_H_EQ_PULSE_LEN   = 58;
    localparam int NTSC_H_BURST_START    = 132;
    localparam int NTSC_H_BURST_END      = 196;
    localparam int NTSC_V_FIELD_HL       = 525;
    localparam int NTSC_V_EQ_HL          = 6;
    localparam int NTSC_V_ACT_START      = 42;
    localparam int NTSC_V_ACT_LINES      = 240;

    localparam int PAL_H_TOTAL           = 1600;
    localparam int PAL_H_SYNC            = 118;
    localparam int PAL_H_BACK_PORCH      = 186;
    localparam int PAL_H_ACTIVE          = 1280;
    localparam int PAL_H_VSYNC_PULSE_LEN = 682;
    localparam int PAL_H_EQ_PULSE_LEN    = 59;
    localparam int PAL_H_BURST_START     = 140;
    localparam int PAL_H_BURST_END       = 196;
    localparam int PAL_V_FIELD_HL        = 625;
    localparam int PAL_V_EQ_HL           = 5;
    localparam int PAL_V_ACT_START       = 46;
    localparam int PAL_V_ACT_LINES       = 288;

    typedef enum logic [1:0] {
        SYNC_NORMAL,
        SYNC_EQ,
        SYNC_BROAD
    } sync_kind_e;

endpackage

// File: rtl/video_sync_pulse.sv
// Composite sync decode: horizontal position plus field-relative half-line -> sync_n.
module video_sync_pulse
    import video_timing_pkg::*;
#(
    parameter int CNT_W             = DEFAULT_CNT_W,
    parameter int H_TOTAL           = NTSC_H_TOTAL,
    parameter int H_SYNC            = NTSC_H_SYNC,
    parameter int H_VSYNC_PULSE_LEN = NTSC_H_VSYNC_PULSE_LEN,
    parameter int H_EQ_PULSE_LEN    = NTSC_H_EQ_PULSE_LEN,
    parameter int V_EQ_HL           = NTSC_V_EQ_HL
) (
    input  logic [CNT_W-1:0] hcnt,
    input  logic [CNT_W-1:0] fcnt,
    output logic             sync_n
);

    localparam logic [CNT_W-1:0] HALF      = CNT_W'(H_TOTAL / 2);
    localparam logic [CNT_W-1:0] EQ_END1   = CNT_W'(V_EQ_HL);
    localparam logic [CNT_W-1:0] BROAD_END = CNT_W'(2 * V_EQ_HL);
    localparam logic [CNT_W-1:0] EQ_END2   = CNT_W'(3 * V_EQ_HL);
    localparam logic [CNT_W-1:0] SYNC_LEN  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] BROAD_LEN = CNT_W'(H_VSYNC_PULSE_LEN);
    localparam logic [CNT_W-1:0] EQ_LEN    = CNT_W'(H_EQ_PULSE_LEN);

    sync_kind_e       kind;
    logic [CNT_W-1:0] hpos;
    logic [CNT_W-1:0] pulse_len;

    always_comb begin
        kind      = SYNC_NORMAL;
        pulse_len = EQ_LEN;
        if (fcnt < EQ_END1) begin
            kind = SYNC_EQ;
        end else if (fcnt < BROAD_END) begin
            kind = SYNC_BROAD;
        end else if (fcnt < EQ_END2) begin
            kind = SYNC_EQ;
        end
        if (kind == SYNC_BROAD) begin
            pulse_len = BROAD_LEN;
        end
        // Vertical-interval pulses repeat every half-line, so measure from the half-line start.
        hpos = (hcnt >= HALF) ? hcnt - HALF : hcnt;
        if (kind == SYNC_NORMAL) begin
            sync_n = !(hcnt < SYNC_LEN);
        end else begin
            sync_n = !(hpos < pulse_len);
        end
    end

endmodule

// File: rtl/video_composite_timing.sv
// Parametrised composite video timing generator (interlaced / progressive, runtime selectable).
// Optional pal_switch output enabled by VIDEO_COMPOSITE_PAL_SWITCH_EN.
module video_composite_timing
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL           = NTSC_H_TOTAL,
    parameter int H_SYNC            = NTSC_H_SYNC,
    parameter int H_BACK_PORCH      = NTSC_H_BACK_PORCH,
    parameter int H_ACTIVE          = NTSC_H_ACTIVE,
    parameter int H_VSYNC_PULSE_LEN = NTSC_H_VSYNC_PULSE_LEN,
    parameter int H_EQ_PULSE_LEN    = NTSC_H_EQ_PULSE_LEN,
    parameter int H_BURST_START     = NTSC_H_BURST_START,
    parameter int H_BURST_END       = NTSC_H_BURST_END,
    parameter int V_FIELD_HL        = NTSC_V_FIELD_HL,
    parameter int V_EQ_HL           = NTSC_V_EQ_HL,
    parameter int V_ACT_START       = NTSC_V_ACT_START,
    parameter int V_ACT_LINES       = NTSC_V_ACT_LINES,
    parameter int CNT_W             = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             progressive,
    output logic             next_frame,
    output logic             next_line,
    output logic             next_pixel,
    output logic             vblank_pulse,
    output logic             current_field,
    output logic             active,
    output logic             color_burst,
    output logic             sync_n,
    output logic [CNT_W-1:0] hcnt,
`ifdef VIDEO_COMPOSITE_PAL_SWITCH_EN
    output logic [CNT_W-1:0] vcnt,
    output logic             pal_switch
`else
    output logic [CNT_W-1:0] vcnt
`endif
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_MID    = CNT_W'(H_TOTAL / 2 - 1);
    localparam logic [CNT_W-1:0] NL_H     = CNT_W'(H_SYNC + H_BACK_PORCH - 1);
    localparam logic [CNT_W-1:0] ACT_H0   = CNT_W'(H_SYNC + H_BACK_PORCH);
    localparam logic [CNT_W-1:0] ACT_H1   = CNT_W'(H_SYNC + H_BACK_PORCH + H_ACTIVE);
    localparam logic [CNT_W-1:0] BURST_H0 = CNT_W'(H_BURST_START);
    localparam logic [CNT_W-1:0] BURST_H1 = CNT_W'(H_BURST_END);
    localparam logic [CNT_W-1:0] V_FIELD  = CNT_W'(V_FIELD_HL);
    localparam logic [CNT_W-1:0] V_LAST_I = CNT_W'(2 * V_FIELD_HL - 1);
    localparam logic [CNT_W-1:0] V_LAST_P = CNT_W'(V_FIELD_HL - 2);
    localparam logic [CNT_W-1:0] F_LAST_I = CNT_W'(V_FIELD_HL - 1);
    localparam logic [CNT_W-1:0] V_ACT0   = CNT_W'(V_ACT_START);
    localparam logic [CNT_W-1:0] V_ACT1   = CNT_W'(V_ACT_START + 2 * V_ACT_LINES);

    logic             prog_q;
    logic             line_act_q;
    logic             armed_q;
    logic             field;
    logic             line_end;
    logic             half_end;
    logic             v_wrap;
    logic             line_act_next;
    logic [CNT_W-1:0] fcnt;
    logic [CNT_W-1:0] vcnt_next;
    logic [CNT_W-1:0] fcnt_next;

    always_comb begin
        line_end      = (hcnt == H_LAST);
        half_end      = line_end || (hcnt == H_MID);
        v_wrap        = half_end && (vcnt == (prog_q ? V_LAST_P : V_LAST_I));
        field         = (vcnt >= V_FIELD);
        fcnt          = field ? vcnt - V_FIELD : vcnt;
        vcnt_next     = v_wrap ? '0 : vcnt + ONE;
        // Line activity is decided from the half-line about to start, so lines are never cut.
        fcnt_next     = (vcnt_next >= V_FIELD) ? vcnt_next - V_FIELD : vcnt_next;
        line_act_next = (fcnt_next >= V_ACT0) && (fcnt_next < V_ACT1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt          <= '0;
            vcnt          <= '0;
            prog_q        <= progressive;
            line_act_q    <= 1'b0;
            armed_q       <= 1'b0;
            current_field <= 1'b0;
        end else begin
            hcnt <= line_end ? '0 : hcnt + ONE;
            if (half_end) begin
                vcnt <= vcnt_next;
            end
            if (v_wrap) begin
                prog_q <= progressive;
            end
            if (next_line) begin
                armed_q <= 1'b0;
            end
            if (line_end) begin
                line_act_q <= line_act_next;
                if (line_act_next && !line_act_q) begin
                    armed_q       <= 1'b1;
                    current_field <= field;
                end
            end
        end
    end

`ifdef VIDEO_COMPOSITE_PAL_SWITCH_EN
    always_ff @(posedge clk) begin
        if (rst || v_wrap) begin
            pal_switch <= 1'b0;
        end else if (line_end) begin
            pal_switch <= ~pal_switch;
        end
    end
`endif

    // Strobes (next_line, next_frame, vblank_pulse) are single-cycle and carry no backpressure.
    assign next_line    = (hcnt == NL_H);
    assign next_frame   = armed_q && next_line;
    assign next_pixel   = (hcnt >= ACT_H0) && (hcnt < ACT_H1);
    assign active       = line_act_q && next_pixel;
    assign color_burst  = line_act_q && (hcnt >= BURST_H0) && (hcnt < BURST_H1);
    assign vblank_pulse = half_end && (fcnt == (prog_q ? V_LAST_P : F_LAST_I));

    video_sync_pulse #(
        .CNT_W            (CNT_W),
        .H_TOTAL          (H_TOTAL),
        .H_SYNC           (H_SYNC),
        .H_VSYNC_PULSE_LEN(H_VSYNC_PULSE_LEN),
        .H_EQ_PULSE_LEN   (H_EQ_PULSE_LEN),
        .V_EQ_HL          (V_EQ_HL)
    ) u_sync (
        .hcnt  (hcnt),
        .fcnt  (fcnt),
        .sync_n(sync_n)
    );

endmodule

// File: tb/tb_video_composite_timing.sv
// Randomised scoreboard bench for video_composite_timing on a reduced geometry.
module tb_video_composite_timing;

    localparam int CNT_W             = 11;
    localparam int H_TOTAL           = 40;
    localparam int H_SYNC            = 4;
    localparam int H_BACK_PORCH      = 6;
    localparam int H_ACTIVE          = 24;
    localparam int H_VSYNC_PULSE_LEN = 16;
    localparam int H_EQ_PULSE_LEN    = 2;
    localparam int H_BURST_START     = 5;
    localparam int H_BURST_END       = 8;
    localparam int V_FIELD_HL        = 31;
    localparam int V_EQ_HL           = 3;
    localparam int V_ACT_START       = 10;
    localparam int V_ACT_LINES       = 8;
    localparam int HL                = H_TOTAL / 2;
    localparam int W                 = 2 * CNT_W + 8;
    localparam int N_CYCLES          = 40000;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             progressive = 1'b0;
    logic             next_frame, next_line, next_pixel, vblank_pulse;
    logic             current_field, active, color_burst, sync_n;
    logic [CNT_W-1:0] hcnt, vcnt;
`ifdef VIDEO_COMPOSITE_PAL_SWITCH_EN
    logic             pal_switch;
    logic             pal_q[$];
`endif

    always #5 clk = ~clk;

    video_composite_timing #(
        .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BACK_PORCH(H_BACK_PORCH), .H_ACTIVE(H_ACTIVE),
        .H_VSYNC_PULSE_LEN(H_VSYNC_PULSE_LEN), .H_EQ_PULSE_LEN(H_EQ_PULSE_LEN),
        .H_BURST_START(H_BURST_START), .H_BURST_END(H_BURST_END), .V_FIELD_HL(V_FIELD_HL),
        .V_EQ_HL(V_EQ_HL), .V_ACT_START(V_ACT_START), .V_ACT_LINES(V_ACT_LINES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .progressive(progressive),
        .next_frame(next_frame), .next_line(next_line), .next_pixel(next_pixel),
        .vblank_pulse(vblank_pulse), .current_field(current_field), .active(active),
        .color_burst(color_burst), .sync_n(sync_n), .hcnt(hcnt),
`ifdef VIDEO_COMPOSITE_PAL_SWITCH_EN
        .vcnt(vcnt), .pal_switch(pal_switch)
`else
        .vcnt(vcnt)
`endif
    );

    // ---------------- reference model ----------------
    // Timing is derived from the clock count t since frame start and the frame's mode.
    int         t = 0;
    bit         mode = 1'b0;
    logic       cf = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         nf_exp = 0;
    int         nf_seen = 0;
    bit         done = 1'b0;
    logic [W-1:0] exp_q[$];

    function automatic int frame_len(input bit m);
        return (m ? V_FIELD_HL - 1 : 2 * V_FIELD_HL) * HL;
    endfunction

    function automatic bit fld(input int v);
        return v >= V_FIELD_HL;
    endfunction

    function automatic int frel(input int v);
        return fld(v) ? v - V_FIELD_HL : v;
    endfunction

    function automatic bit line_on(input int l);
        int f;
        f = frel(2 * l);
        return (f >= V_ACT_START) && (f < V_ACT_START + 2 * V_ACT_LINES);
    endfunction

    function automatic bit sync_low(input int h, input int f);
        int len;
        if (f < V_EQ_HL || (f >= 2 * V_EQ_HL && f < 3 * V_EQ_HL)) len = H_EQ_PULSE_LEN;
        else if (f < 2 * V_EQ_HL) len = H_VSYNC_PULSE_LEN;
        else return h < H_SYNC;
        return (h < len) || (h >= HL && h < HL + len);
    endfunction

    task automatic model_step();
        int   h, v, l;
        logic first, nl, nf, hact, vb, la, burst, sn;
        if (rst) begin
            t    = 0;
            mode = progressive;
            cf   = 1'b0;
        end else begin
            t++;
            if (t == frame_len(mode)) begin
                t    = 0;
                mode = progressive;
            end
        end
        h     = t % H_TOTAL;
        v     = t / HL;
        l     = t / H_TOTAL;
        la    = line_on(l);
        first = (l > 0) && la && !line_on(l - 1);
        if (!rst && h == 0 && first) cf = fld(2 * l - 1);
        nl    = (h == H_SYNC + H_BACK_PORCH - 1);
        nf    = nl && first;
        hact  = (h >= H_SYNC + H_BACK_PORCH) && (h < H_SYNC + H_BACK_PORCH + H_ACTIVE);
        vb    = ((t + 1) % HL == 0) && (frel(v) == (mode ? V_FIELD_HL - 2 : V_FIELD_HL - 1));
        burst = la && (h >= H_BURST_START) && (h < H_BURST_END);
        sn    = !sync_low(h, frel(v));
        if (nf) nf_exp++;
        exp_q.push_back({CNT_W'(h), CNT_W'(v), nf, nl, hact, vb, cf, la && hact, burst, sn});
`ifdef VIDEO_COMPOSITE_PAL_SWITCH_EN
        pal_q.push_back(l[0]);
`endif
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- driver ----------------
    initial begin
        for (int c = 0; c < N_CYCLES; c++) begin
            @(negedge clk);
            rst = (c < 3) || (c == 15000) || ($urandom_range(0, 9999) == 0);
            if ($urandom_range(0, 799) == 0) progressive = ~progressive;
            model_step();
        end
        @(posedge clk);
        #2;
        done = 1'b1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("next_frame_count", 32'(nf_seen), 32'(nf_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!done && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (next_frame === 1'b1) nf_seen++;
                check("hcnt", 32'(hcnt), 32'(e[W-1 -: CNT_W]));
                check("vcnt", 32'(vcnt), 32'(e[W-CNT_W-1 -: CNT_W]));
                check("flags{nf,nl,np,vb,cf,act,burst,sync_n}",
                      32'({next_frame, next_line, next_pixel, vblank_pulse,
                           current_field, active, color_burst, sync_n}),
                      32'(e[7:0]));
`ifdef VIDEO_COMPOSITE_PAL_SWITCH_EN
                check("pal_switch", 32'(pal_switch), 32'(pal_q.pop_front()));
`endif
            end
        end
    end

endmodule
